ls_station: RTL and testbench



---
 rtl/ls_station_pkg.sv | 33 +++
 rtl/ls_station_tag_match.sv | 20 ++
 rtl/ls_station.sv | 164 ++++++++++++++++
 tb/tb_ls_station.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_station_pkg.sv
// rtl/ls_station_pkg.sv - shared constants and types for the load/store reservation station
package ls_station_pkg;

   localparam int LSS_DEPTH   = 4;
   localparam int LSS_ENTRY_W = 42;
   localparam int PREG_W      = 6;
   localparam int ROB_W       = 4;
   localparam int IMM_W       = 16;

   localparam int MEM_REN_BIT = 41;
   localparam int MEM_WEN_BIT = 40;
   localparam int ROB_MSB     = 39;
   localparam int ROB_LSB     = 36;
   localparam int PRD_MSB     = 35;
   localparam int PRD_LSB     = 30;
   localparam int PRS_MSB     = 29;
   localparam int PRS_LSB     = 24;
   localparam int VRS_BIT     = 23;
   localparam int PRT_MSB     = 22;
   localparam int PRT_LSB     = 17;
   localparam int VRT_BIT     = 16;
   localparam int IMM_MSB     = 15;
   localparam int IMM_LSB     = 0;

   typedef logic [LSS_ENTRY_W-1:0] lss_entry_t;
   typedef logic [LSS_DEPTH-1:0]   lss_ptr_t;

   // one-hot pointer advance: 0001 -> 0010 -> 0100 -> 1000 -> 0001
   function automatic lss_ptr_t lss_rotl(input lss_ptr_t p);
      return {p[LSS_DEPTH-2:0], p[LSS_DEPTH-1]};
   endfunction

endpackage

// File: rtl/ls_station_tag_match.sv
// rtl/ls_station_tag_match.sv - compares one completing tag against every entry's source tag
module ls_station_tag_match
   import ls_station_pkg::*;
(
   input  logic                             en_i,
   input  logic [PREG_W-1:0]                tag_i,
   input  logic [LSS_DEPTH-1:0][PREG_W-1:0] entry_tags_i,
   input  logic [LSS_DEPTH-1:0]             valid_i,
   output logic [LSS_DEPTH-1:0]             match_o
);

   // an entry matches only when it is occupied and a register-writing completion is present
   always_comb begin
      match_o = '0;
      for (int i = 0; i < LSS_DEPTH; i++) begin
         match_o[i] = en_i & valid_i[i] & (entry_tags_i[i] == tag_i);
      end
   end

endmodule

// File: rtl/ls_station.sv
// rtl/ls_station.sv - 4-entry in-order load/store reservation station
module ls_station
   import ls_station_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              isDispatch,
   input  logic [ROB_W-1:0]  rob_num_dp,
   input  logic [PREG_W-1:0] p_rd_new,
   input  logic [PREG_W-1:0] p_rs,
   input  logic              v_rs,
   input  logic [PREG_W-1:0] p_rt,
   input  logic              v_rt,
   input  logic              mem_ren,
   input  logic              mem_wen,
   input  logic [IMM_W-1:0]  immed,
   input  logic              stall_hazard,
   input  logic              recover,
   input  logic [ROB_W-1:0]  rob_num_rec,
   input  logic [PREG_W-1:0] p_rd_compl,
   input  logic              RegDest_compl,
   input  logic              complete,
   output logic [PREG_W-1:0] p_rs_out,
   output logic [PREG_W-1:0] p_rt_out,
   output logic [PREG_W-1:0] p_rd_out,
   output logic [IMM_W-1:0]  immed_out,
   output logic              RegDest_out,
   output logic              mem_ren_out,
   output logic              mem_wen_out,
   output logic              issue,
   output logic              lss_full
);

   logic [LSS_DEPTH-1:0][LSS_ENTRY_W-1:0] entry_q, entry_d;
   lss_ptr_t                              valid_q, valid_d;
   lss_ptr_t                              head_q, head_d;
   lss_ptr_t                              tail_q, tail_d;

   logic [LSS_DEPTH-1:0][PREG_W-1:0]      rs_tags, rt_tags;
   logic [LSS_DEPTH-1:0]                  rs_match_array, rt_match_array;
   logic                                  snoop_en;
   logic                                  dispatch;
   logic                                  retire;
   logic                                  head_valid, head_vrs, head_vrt;
   lss_entry_t                            dp_entry;

   assign snoop_en = complete & RegDest_compl;
   assign lss_full = &valid_q;
   assign dispatch = isDispatch & (mem_ren | mem_wen) & ~lss_full & ~recover;

   // gather per-entry source tags for the two snoop comparators
   always_comb begin
      rs_tags = '0;
      rt_tags = '0;
      for (int i = 0; i < LSS_DEPTH; i++) begin
         rs_tags[i] = entry_q[i][PRS_MSB:PRS_LSB];
         rt_tags[i] = entry_q[i][PRT_MSB:PRT_LSB];
      end
   end

   ls_station_tag_match u_rs_match (
      .en_i         (snoop_en),
      .tag_i        (p_rd_compl),
      .entry_tags_i (rs_tags),
      .valid_i      (valid_q),
      .match_o      (rs_match_array)
   );

   ls_station_tag_match u_rt_match (
      .en_i         (snoop_en),
      .tag_i        (p_rd_compl),
      .entry_tags_i (rt_tags),
      .valid_i      (valid_q),
      .match_o      (rt_match_array)
   );

   // expose the head entry's fields; data is shown even when the slot is empty
   always_comb begin
      p_rs_out    = '0;
      p_rt_out    = '0;
      p_rd_out    = '0;
      immed_out   = '0;
      mem_ren_out = 1'b0;
      mem_wen_out = 1'b0;
      head_vrs    = 1'b0;
      head_vrt    = 1'b0;
      for (int i = 0; i < LSS_DEPTH; i++) begin
         if (head_q[i]) begin
            p_rs_out    = entry_q[i][PRS_MSB:PRS_LSB];
            p_rt_out    = entry_q[i][PRT_MSB:PRT_LSB];
            p_rd_out    = entry_q[i][PRD_MSB:PRD_LSB];
            immed_out   = entry_q[i][IMM_MSB:IMM_LSB];
            mem_ren_out = entry_q[i][MEM_REN_BIT];
            mem_wen_out = entry_q[i][MEM_WEN_BIT];
            head_vrs    = entry_q[i][VRS_BIT];
            head_vrt    = entry_q[i][VRT_BIT];
         end
      end
   end

   assign RegDest_out = mem_ren_out;
   assign head_valid  = |(valid_q & head_q);
   assign issue       = head_valid & head_vrs & head_vrt & (mem_ren_out | mem_wen_out)
                        & ~stall_hazard & ~recover;
   // a squashed op at the head leaves silently, regardless of readiness or stall
   assign retire      = head_valid & ~(mem_ren_out | mem_wen_out) & ~recover;

   // build the incoming entry, catching a completion that arrives in the same cycle
   always_comb begin
      dp_entry                  = '0;
      dp_entry[MEM_REN_BIT]     = mem_ren;
      dp_entry[MEM_WEN_BIT]     = mem_wen;
      dp_entry[ROB_MSB:ROB_LSB] = rob_num_dp;
      dp_entry[PRD_MSB:PRD_LSB] = p_rd_new;
      dp_entry[PRS_MSB:PRS_LSB] = p_rs;
      dp_entry[VRS_BIT]         = v_rs | (snoop_en & (p_rs == p_rd_compl));
      dp_entry[PRT_MSB:PRT_LSB] = p_rt;
      dp_entry[VRT_BIT]         = v_rt | (snoop_en & (p_rt == p_rd_compl));
      dp_entry[IMM_MSB:IMM_LSB] = immed;
   end

   // next-state: snoop wakeup, recovery squash, head advance, tail write
   always_comb begin
      entry_d = entry_q;
      valid_d = valid_q;
      head_d  = head_q;
      tail_d  = tail_q;
      for (int i = 0; i < LSS_DEPTH; i++) begin
         if (rs_match_array[i]) entry_d[i][VRS_BIT] = 1'b1;
         if (rt_match_array[i]) entry_d[i][VRT_BIT] = 1'b1;
         if (recover && valid_q[i] && (entry_q[i][ROB_MSB:ROB_LSB] == rob_num_rec)) begin
            entry_d[i][MEM_REN_BIT] = 1'b0;
            entry_d[i][MEM_WEN_BIT] = 1'b0;
         end
      end
      if (issue || retire) begin
         valid_d = valid_d & ~head_q;
         head_d  = lss_rotl(head_q);
      end
      if (dispatch) begin
         for (int i = 0; i < LSS_DEPTH; i++) begin
            if (tail_q[i]) entry_d[i] = dp_entry;
         end
         valid_d = valid_d | tail_q;
         tail_d  = lss_rotl(tail_q);
      end
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         entry_q <= '0;
         valid_q <= '0;
         head_q  <= 4'b0001;
         tail_q  <= 4'b0001;
      end else begin
         entry_q <= entry_d;
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

endmodule

// File: tb/tb_ls_station.sv
// tb/tb_ls_station.sv - self-checking bench for the load/store reservation station
module tb_ls_station;

   logic        clk = 1'b0;
   logic        rst, isDispatch, v_rs, v_rt, mem_ren, mem_wen;
   logic [3:0]  rob_num_dp, rob_num_rec;
   logic [5:0]  p_rd_new, p_rs, p_rt, p_rd_compl;
   logic [15:0] immed;
   logic        stall_hazard, recover, RegDest_compl, complete;
   logic [5:0]  p_rs_out, p_rt_out, p_rd_out;
   logic [15:0] immed_out;
   logic        RegDest_out, mem_ren_out, mem_wen_out, issue, lss_full;

   always #5 clk = ~clk;

   ls_station dut (
      .clk(clk), .rst(rst), .isDispatch(isDispatch), .rob_num_dp(rob_num_dp),
      .p_rd_new(p_rd_new), .p_rs(p_rs), .v_rs(v_rs), .p_rt(p_rt), .v_rt(v_rt),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .immed(immed), .stall_hazard(stall_hazard),
      .recover(recover), .rob_num_rec(rob_num_rec), .p_rd_compl(p_rd_compl),
      .RegDest_compl(RegDest_compl), .complete(complete), .p_rs_out(p_rs_out),
      .p_rt_out(p_rt_out), .p_rd_out(p_rd_out), .immed_out(immed_out),
      .RegDest_out(RegDest_out), .mem_ren_out(mem_ren_out), .mem_wen_out(mem_wen_out),
      .issue(issue), .lss_full(lss_full)
   );

   wire [36:0] a_data = {p_rs_out, p_rt_out, p_rd_out, immed_out, RegDest_out, mem_ren_out, mem_wen_out};

   typedef struct packed {
      logic       ren, wen;
      logic [3:0] rob;
      logic [5:0] prd, prs;
      logic       vrs;
      logic [5:0] prt;
      logic       vrt;
      logic [15:0] imm;
   } op_t;

   // program-order ring: slots keep stale contents after leaving, occupancy is a count
   op_t   m [4];
   int    hd, tl, cnt;
   int    checks = 0, errors = 0;
   logic  e_issue, e_full;
   logic [36:0] e_data;

   function automatic logic [36:0] pack_out(input op_t o);
      return {o.prs, o.prt, o.prd, o.imm, o.ren, o.ren, o.wen};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m[i] = '0;
      hd = 0; tl = 0; cnt = 0;
   endtask

   task automatic model_eval();
      op_t h;
      h = m[hd];
      e_full  = (cnt == 4);
      e_issue = (cnt > 0) && h.vrs && h.vrt && (h.ren || h.wen) && !stall_hazard && !recover;
      e_data  = pack_out(h);
   endtask

   // advance the reference by one clock using the current inputs, then let the DUT take the edge
   task automatic clock_model();
      logic sn, adv, disp;
      int   idx;
      op_t  n;
      model_eval();
      sn   = complete & RegDest_compl;
      adv  = e_issue || ((cnt > 0) && !(m[hd].ren || m[hd].wen) && !recover);
      disp = isDispatch && (mem_ren || mem_wen) && (cnt != 4) && !recover;
      for (int k = 0; k < cnt; k++) begin
         idx = (hd + k) % 4;
         if (sn && m[idx].prs == p_rd_compl) m[idx].vrs = 1'b1;
         if (sn && m[idx].prt == p_rd_compl) m[idx].vrt = 1'b1;
         if (recover && m[idx].rob == rob_num_rec) begin
            m[idx].ren = 1'b0;
            m[idx].wen = 1'b0;
         end
      end
      if (adv) begin
         hd  = (hd + 1) % 4;
         cnt = cnt - 1;
      end
      if (disp) begin
         n.ren = mem_ren; n.wen = mem_wen; n.rob = rob_num_dp; n.prd = p_rd_new;
         n.prs = p_rs; n.vrs = v_rs | (sn && p_rs == p_rd_compl);
         n.prt = p_rt; n.vrt = v_rt | (sn && p_rt == p_rd_compl);
         n.imm = immed;
         m[tl] = n;
         tl  = (tl + 1) % 4;
         cnt = cnt + 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      isDispatch = 0; rob_num_dp = 0; p_rd_new = 0; p_rs = 0; v_rs = 0; p_rt = 0; v_rt = 0;
      mem_ren = 0; mem_wen = 0; immed = 0; stall_hazard = 0; recover = 0; rob_num_rec = 0;
      p_rd_compl = 0; RegDest_compl = 0; complete = 0;
   endtask

   task automatic drive_dp(input logic ren, input logic wen, input logic [3:0] rob,
                           input logic [5:0] prd, input logic [5:0] prs, input logic vs,
                           input logic [5:0] prt, input logic vt, input logic [15:0] imm);
      isDispatch = 1; mem_ren = ren; mem_wen = wen; rob_num_dp = rob; p_rd_new = prd;
      p_rs = prs; v_rs = vs; p_rt = prt; v_rt = vt; immed = imm;
   endtask

   task automatic do_reset();
      idle();
      rst = 0;
      @(posedge clk);
      #1;
      rst = 1;
      model_reset();
   endtask

   task automatic test_reset();
      idle();
      isDispatch = 1; mem_ren = 1; v_rs = 1; v_rt = 1; immed = 16'hbeef;
      rst = 0;
      @(posedge clk);
      #1;
      rst = 1;
      idle();
      model_reset();
      #1;
      checks++; if (issue !== 1'b0) begin errors++; $display("FAIL reset_issue: got %b want 0", issue); end
      checks++; if (lss_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", lss_full); end
      checks++; if (a_data !== 37'd0) begin errors++; $display("FAIL reset_data: got %h want 0", a_data); end
   endtask

   task automatic test_fill_issue_recover_stall();
      logic [36:0] ld_out, sw1_out, sw2_out, sw3_out;
      ld_out  = {6'd3, 6'd5, 6'd5, 16'h0100, 1'b1, 1'b1, 1'b0};
      sw1_out = {6'd3, 6'd2, 6'd0, 16'h0010, 1'b0, 1'b0, 1'b1};
      sw2_out = {6'd3, 6'd2, 6'd0, 16'h0020, 1'b0, 1'b0, 1'b0};
      sw3_out = {6'd3, 6'd2, 6'd0, 16'h0030, 1'b0, 1'b0, 1'b1};
      do_reset();
      // non-memory op is ignored
      drive_dp(0, 0, 4'd9, 6'd7, 6'd1, 1, 6'd2, 1, 16'h1111);
      clock_model();
      idle(); #1;
      checks++; if (lss_full !== 1'b0 || issue !== 1'b0) begin errors++; $display("FAIL add_ignored: got full=%b issue=%b want 0/0", lss_full, issue); end
      // LD then three SWs fill the ring
      drive_dp(1, 0, 4'd1, 6'd5, 6'd3, 0, 6'd5, 1, 16'h0100); clock_model();
      drive_dp(0, 1, 4'd3, 6'd0, 6'd3, 1, 6'd2, 0, 16'h0010); clock_model();
      drive_dp(0, 1, 4'd4, 6'd0, 6'd3, 1, 6'd2, 0, 16'h0020); clock_model();
      drive_dp(0, 1, 4'd5, 6'd0, 6'd3, 1, 6'd2, 0, 16'h0030); #1;
      checks++; if (lss_full !== 1'b0) begin errors++; $display("FAIL three_not_full: got %b want 0", lss_full); end
      clock_model();
      // fifth dispatch is dropped
      drive_dp(1, 0, 4'd7, 6'd9, 6'd9, 1, 6'd9, 1, 16'hffff); #1;
      checks++; if (lss_full !== 1'b1) begin errors++; $display("FAIL full: got %b want 1", lss_full); end
      clock_model();
      idle(); #1;
      checks++; if (a_data !== ld_out) begin errors++; $display("FAIL drop_when_full: got %h want %h", a_data, ld_out); end
      checks++; if (issue !== 1'b0) begin errors++; $display("FAIL ld_not_ready: got %b want 0", issue); end
      // wake LD's rs
      complete = 1; RegDest_compl = 1; p_rd_compl = 6'd3;
      clock_model();
      idle(); #1;
      checks++; if (issue !== 1'b1) begin errors++; $display("FAIL ld_issue: got %b want 1", issue); end
      checks++; if (a_data !== ld_out) begin errors++; $display("FAIL ld_fields: got %h want %h", a_data, ld_out); end
      // wake the stores' rt while LD issues
      complete = 1; RegDest_compl = 1; p_rd_compl = 6'd2;
      clock_model();
      idle(); #1;
      checks++; if (issue !== 1'b1 || lss_full !== 1'b0) begin errors++; $display("FAIL sw1_issue: got issue=%b full=%b want 1/0", issue, lss_full); end
      checks++; if (a_data !== sw1_out) begin errors++; $display("FAIL sw1_fields: got %h want %h", a_data, sw1_out); end
      // recovery squashes rob 4 and blocks issue
      recover = 1; rob_num_rec = 4'd4; #1;
      checks++; if (issue !== 1'b0) begin errors++; $display("FAIL recover_blocks: got %b want 0", issue); end
      clock_model();
      idle(); #1;
      checks++; if (issue !== 1'b1 || a_data !== sw1_out) begin errors++; $display("FAIL head_held: got issue=%b data=%h want 1/%h", issue, a_data, sw1_out); end
      clock_model();
      #1;
      checks++; if (issue !== 1'b0 || a_data !== sw2_out) begin errors++; $display("FAIL squashed_retire: got issue=%b data=%h want 0/%h", issue, a_data, sw2_out); end
      clock_model();
      // stall holds a ready head
      stall_hazard = 1; #1;
      checks++; if (issue !== 1'b0) begin errors++; $display("FAIL stall_blocks: got %b want 0", issue); end
      clock_model();
      #1;
      checks++; if (issue !== 1'b0 || a_data !== sw3_out) begin errors++; $display("FAIL stall_holds: got issue=%b data=%h want 0/%h", issue, a_data, sw3_out); end
      stall_hazard = 0; #1;
      checks++; if (issue !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", issue); end
      clock_model();
      #1;
      checks++; if (issue !== 1'b0 || lss_full !== 1'b0) begin errors++; $display("FAIL drained: got issue=%b full=%b want 0/0", issue, lss_full); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         drive_dp(1, 0, k[3:0], k[5:0], k[5:0], 1, k[5:0] + 6'd1, 1, k[15:0] + 16'h0a00);
         #1;
         model_eval();
         checks++; if (issue !== e_issue || issue !== (k > 0)) begin errors++; $display("FAIL b2b_issue[%0d]: got %b want %b", k, issue, e_issue); end
         checks++; if (a_data !== e_data) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", k, a_data, e_data); end
         clock_model();
      end
      idle(); #1;
      checks++; if (issue !== 1'b1) begin errors++; $display("FAIL b2b_last: got %b want 1", issue); end
      clock_model();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         isDispatch    = ($urandom_range(0, 3) != 0);
         mem_ren       = $urandom_range(0, 1);
         mem_wen       = $urandom_range(0, 1);
         rob_num_dp    = 4'($urandom_range(0, 7));
         p_rd_new      = 6'($urandom_range(0, 63));
         p_rs          = 6'($urandom_range(0, 7));
         p_rt          = 6'($urandom_range(0, 7));
         v_rs          = $urandom_range(0, 1);
         v_rt          = $urandom_range(0, 1);
         immed         = 16'($urandom);
         stall_hazard  = ($urandom_range(0, 3) == 0);
         recover       = ($urandom_range(0, 11) == 0);
         rob_num_rec   = 4'($urandom_range(0, 7));
         complete      = $urandom_range(0, 1);
         RegDest_compl = ($urandom_range(0, 3) != 0);
         p_rd_compl    = 6'($urandom_range(0, 7));
         #1;
         model_eval();
         checks++; if (issue !== e_issue) begin errors++; $display("FAIL rand_issue[%0d]: got %b want %b", c, issue, e_issue); end
         checks++; if (lss_full !== e_full) begin errors++; $display("FAIL rand_full[%0d]: got %b want %b", c, lss_full, e_full); end
         checks++; if (a_data !== e_data) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", c, a_data, e_data); end
         clock_model();
      end
   endtask

   initial begin
      idle();
      rst = 1;
      model_reset();
      test_reset();
      test_fill_issue_recover_stall();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
